axi_write_scheduler: RTL and testbench

Control block for the AXI write path (AW, W, B) between two write masters (M0, M1) and three slaves (S0, S1, S2). It round-robin arbitrates AW requests, decodes the target slave, and owns the write transaction until the B handshake completes. It drives the select lines that steer the external address, data and response muxes. Unmapped addresses go to an internal default slave that returns DECERR. Exactly one write transaction is outstanding at a time.

---
 rtl/axi_write_scheduler.sv | 161 ++++++++++++++++
 tb/tb_axi_write_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_scheduler.sv
// Write-path scheduler for two AXI masters and three slaves plus an internal DECERR slave.
// Owns one AW/W/B transaction at a time and drives the steering selects for the external muxes.
module axi_write_scheduler #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        awvalid_m,
  input  logic [ADDR_W-1:0] awaddr_m0,
  input  logic [ADDR_W-1:0] awaddr_m1,
  input  logic [LEN_W-1:0]  awlen_m0,
  input  logic [LEN_W-1:0]  awlen_m1,
  output logic [1:0]        awready_m,
  output logic [2:0]        awvalid_s,
  input  logic [2:0]        awready_s,
  input  logic [1:0]        wvalid_m,
  input  logic [1:0]        wlast_m,
  output logic [1:0]        wready_m,
  output logic [2:0]        wvalid_s,
  input  logic [2:0]        wready_s,
  input  logic [2:0]        bvalid_s,
  output logic [2:0]        bready_s,
  output logic [1:0]        bvalid_m,
  input  logic [1:0]        bready_m,
  output logic              mst_sel,
  output logic [1:0]        slv_sel,
  output logic [1:0]        dflt_bresp,
  output logic              len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t             state;
  logic               rr_last;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;

  logic               grant;
  logic [ADDR_W-1:0]  grant_addr;
  logic [LEN_W-1:0]   grant_len;
  logic               dflt;
  logic [2:0]         slv_oh;
  logic [1:0]         mst_oh;
  logic               m_awvalid, m_wvalid, m_wlast, m_bready;
  logic               s_awready, s_wready, s_bvalid;
  logic               aw_hs, w_hs, b_hs;
  logic               unused_addr_lsbs;

  function automatic logic arb(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  function automatic logic [1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-17:0] hi;
    hi = addr[ADDR_W-1:16];
    if (hi == (ADDR_W-16)'(0)) return 2'd0;
    if (hi == (ADDR_W-16)'(1)) return 2'd1;
    if (hi == (ADDR_W-16)'(2)) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    if (&v) return v;
    return v + LEN_W'(1);
  endfunction

  assign unused_addr_lsbs = ^{awaddr_m0[15:0], awaddr_m1[15:0]};

  assign grant      = arb(awvalid_m, rr_last);
  assign grant_addr = grant ? awaddr_m1 : awaddr_m0;
  assign grant_len  = grant ? awlen_m1 : awlen_m0;

  // Latched selects expanded to one-hot lanes; slave lanes are all-zero for the default slave.
  assign dflt   = (slv_sel == 2'd3);
  assign slv_oh = dflt ? 3'b000 : (3'b001 << slv_sel);
  assign mst_oh = mst_sel ? 2'b10 : 2'b01;

  assign m_awvalid = awvalid_m[mst_sel];
  assign m_wvalid  = wvalid_m[mst_sel];
  assign m_wlast   = wlast_m[mst_sel];
  assign m_bready  = bready_m[mst_sel];
  assign s_awready = |(awready_s & slv_oh);
  assign s_wready  = |(wready_s & slv_oh);
  assign s_bvalid  = |(bvalid_s & slv_oh);

  assign aw_hs = (state == ADDR) && m_awvalid && (dflt || s_awready);
  assign w_hs  = (state == DATA) && m_wvalid && (dflt || s_wready);
  assign b_hs  = (state == RESP) && m_bready && (dflt || s_bvalid);

  always_comb begin
    awready_m  = 2'b00;
    awvalid_s  = 3'b000;
    wready_m   = 2'b00;
    wvalid_s   = 3'b000;
    bvalid_m   = 2'b00;
    bready_s   = 3'b000;
    dflt_bresp = 2'b00;
    case (state)
      ADDR: begin
        awvalid_s = slv_oh & {3{m_awvalid}};
        awready_m = mst_oh & {2{dflt | s_awready}};
      end
      DATA: begin
        wvalid_s = slv_oh & {3{m_wvalid}};
        wready_m = mst_oh & {2{dflt | s_wready}};
      end
      RESP: begin
        bvalid_m   = mst_oh & {2{dflt | s_bvalid}};
        bready_s   = slv_oh & {3{m_bready}};
        dflt_bresp = dflt ? 2'b11 : 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mst_sel <= 1'b0;
      slv_sel <= 2'd0;
      len_err <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|awvalid_m) begin
            mst_sel <= grant;
            slv_sel <= decode(grant_addr);
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) state <= DATA;
        end
        DATA: begin
          if (w_hs) begin
            if (m_wlast != (beat_cnt == len_q)) len_err <= 1'b1;
            if (m_wlast) state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            rr_last <= mst_sel;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Burst bookkeeping carries no reset: it is reloaded on every grant and AW handshake.
  always_ff @(posedge clk) begin
    if (state == IDLE && |awvalid_m) len_q <= grant_len;
    if (aw_hs)     beat_cnt <= '0;
    else if (w_hs) beat_cnt <= sat_inc(beat_cnt);
  end

endmodule

// File: tb/tb_axi_write_scheduler.sv
// Directed and randomized bench for axi_write_scheduler: the bench plays both masters and all
// slaves, predicting grants, routing and the sticky length error from the transaction rules.
module tb_axi_write_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  awvalid_m;
  logic [31:0] awaddr_m0, awaddr_m1;
  logic [3:0]  awlen_m0, awlen_m1;
  logic [1:0]  awready_m;
  logic [2:0]  awvalid_s, awready_s;
  logic [1:0]  wvalid_m, wlast_m, wready_m;
  logic [2:0]  wvalid_s, wready_s, bvalid_s, bready_s;
  logic [1:0]  bvalid_m, bready_m;
  logic        mst_sel;
  logic [1:0]  slv_sel, dflt_bresp;
  logic        len_err;

  int n_pass  = 0;
  int n_total = 0;
  int exp_rr  = 1;
  bit exp_err = 1'b0;
  logic [31:0] addr_a [2];
  logic [3:0]  len_a  [2];

  axi_write_scheduler #(.ADDR_W(32), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .awvalid_m(awvalid_m), .awaddr_m0(awaddr_m0), .awaddr_m1(awaddr_m1),
    .awlen_m0(awlen_m0), .awlen_m1(awlen_m1), .awready_m(awready_m),
    .awvalid_s(awvalid_s), .awready_s(awready_s),
    .wvalid_m(wvalid_m), .wlast_m(wlast_m), .wready_m(wready_m),
    .wvalid_s(wvalid_s), .wready_s(wready_s),
    .bvalid_s(bvalid_s), .bready_s(bready_s), .bvalid_m(bvalid_m), .bready_m(bready_m),
    .mst_sel(mst_sel), .slv_sel(slv_sel), .dflt_bresp(dflt_bresp), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int slv_of(input logic [31:0] a);
    int hi;
    hi = int'(a >> 16);
    return (hi < 3) ? hi : 3;
  endfunction

  task automatic idle_inputs();
    awvalid_m = 2'b00; awready_s = 3'b000;
    wvalid_m  = 2'b00; wlast_m   = 2'b00; wready_s = 3'b000;
    bvalid_s  = 3'b000; bready_m = 2'b00;
    awaddr_m0 = addr_a[0]; awaddr_m1 = addr_a[1];
    awlen_m0  = len_a[0];  awlen_m1  = len_a[1];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready_m"}, 32'(awready_m), 0);
    chk({tag, "_awvalid_s"}, 32'(awvalid_s), 0);
    chk({tag, "_wready_m"},  32'(wready_m),  0);
    chk({tag, "_wvalid_s"},  32'(wvalid_s),  0);
    chk({tag, "_bready_s"},  32'(bready_s),  0);
    chk({tag, "_bvalid_m"},  32'(bvalid_m),  0);
    chk({tag, "_mst_sel"},   32'(mst_sel),   0);
    chk({tag, "_slv_sel"},   32'(slv_sel),   0);
    chk({tag, "_bresp"},     32'(dflt_bresp), 0);
    chk({tag, "_len_err"},   32'(len_err),   0);
  endtask

  // One complete transaction; nb<=0 sends exactly AWLEN+1 beats, abort_at>=0 resets mid-burst.
  task automatic txn(input logic [1:0] req, input int nb_in, input int aw_dly, input int w_stall,
                     input int b_dly, input int abort_at);
    int g, s, nb, stall;
    bit dflt, rdy;
    logic [2:0] smask;
    logic [1:0] gmask;
    g     = (req == 2'b11) ? (exp_rr == 1 ? 0 : 1) : (req[1] ? 1 : 0);
    s     = slv_of(addr_a[g]);
    dflt  = (s == 3);
    smask = dflt ? 3'b000 : 3'(1 << s);
    gmask = 2'(1 << g);
    nb    = (nb_in <= 0) ? int'(len_a[g]) + 1 : nb_in;

    // Request cycle: W is offered early and must not be accepted.
    @(negedge clk);
    idle_inputs();
    awvalid_m = req;
    wvalid_m  = gmask;
    wlast_m   = (nb == 1) ? gmask : 2'b00;
    #1;
    chk("idle_awready_m", 32'(awready_m), 0);
    chk("idle_awvalid_s", 32'(awvalid_s), 0);
    chk("early_wready_m", 32'(wready_m), 0);
    @(posedge clk);

    for (int c = 0; c <= aw_dly; c++) begin
      @(negedge clk);
      awready_s = 3'($urandom) & ~smask;
      if (c == aw_dly) awready_s = awready_s | smask;
      #1;
      chk("mst_sel", 32'(mst_sel), 32'(g));
      chk("slv_sel", 32'(slv_sel), 32'(s));
      chk("awvalid_s", 32'(awvalid_s), 32'(smask));
      chk("awready_m", 32'(awready_m), (dflt || c == aw_dly) ? 32'(gmask) : 0);
      chk("addr_wready_m", 32'(wready_m), 0);
      chk("addr_wvalid_s", 32'(wvalid_s), 0);
      @(posedge clk);
      if (dflt) break;
    end

    for (int i = 0; i < nb; i++) begin
      stall = (dflt || i != nb / 2) ? 0 : w_stall;
      for (int st = 0; st <= stall; st++) begin
        @(negedge clk);
        if (i == abort_at && st == 0) begin
          rst = 1'b0;
          #1;
          chk_all_zero("abort");
          @(posedge clk);
          @(negedge clk);
          idle_inputs();
          rst = 1'b1;
          exp_rr  = 1;
          exp_err = 1'b0;
          return;
        end
        awvalid_m = awvalid_m & ~gmask;
        awready_s = 3'b000;
        wvalid_m  = gmask;
        wlast_m   = (i == nb - 1) ? gmask : 2'b00;
        rdy       = (st == stall);
        wready_s  = (3'($urandom) & ~smask) | (rdy ? smask : 3'b000);
        #1;
        chk("wvalid_s", 32'(wvalid_s), 32'(smask));
        chk("wready_m", 32'(wready_m), (dflt || rdy) ? 32'(gmask) : 0);
        chk("data_bvalid_m", 32'(bvalid_m), 0);
        chk("data_bready_s", 32'(bready_s), 0);
        chk("data_awready_m", 32'(awready_m), 0);
        @(posedge clk);
      end
    end

    for (int c = 0; c <= (dflt ? 0 : b_dly); c++) begin
      @(negedge clk);
      wvalid_m = 2'b00; wlast_m = 2'b00; wready_s = 3'b000;
      bvalid_s = (3'($urandom) & ~smask) | ((c == b_dly) ? smask : 3'b000);
      bready_m = (2'($urandom) & ~gmask) | ((c == b_dly || dflt) ? gmask : 2'($urandom) & gmask);
      #1;
      chk("bvalid_m", 32'(bvalid_m), (dflt || c == b_dly) ? 32'(gmask) : 0);
      chk("bready_s", 32'(bready_s), (bready_m & gmask) != 0 ? 32'(smask) : 0);
      chk("dflt_bresp", 32'(dflt_bresp), dflt ? 32'd3 : 0);
      chk("resp_wready_m", 32'(wready_m), 0);
      @(posedge clk);
    end

    exp_rr  = g;
    exp_err = exp_err | (nb != int'(len_a[g]) + 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("len_err", 32'(len_err), 32'(exp_err));
    chk("post_bvalid_m", 32'(bvalid_m), 0);
    chk("post_awready_m", 32'(awready_m), 0);
  endtask

  initial begin
    logic [15:0] hi_tab [5];
    hi_tab[0] = 16'h0000; hi_tab[1] = 16'h0001; hi_tab[2] = 16'h0002;
    hi_tab[3] = 16'h0003; hi_tab[4] = 16'hffff;
    addr_a[0] = 32'h0; addr_a[1] = 32'h0; len_a[0] = 4'd0; len_a[1] = 4'd0;
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // Single-beat write from M0 to S1.
    addr_a[0] = 32'h0001_0004; len_a[0] = 4'd0;
    txn(2'b01, 0, 0, 0, 0, -1);

    // Both masters contend for S2 over four bursts.
    addr_a[0] = 32'h0002_0000; addr_a[1] = 32'h0002_0040;
    len_a[0] = 4'd1; len_a[1] = 4'd1;
    repeat (4) txn(2'b11, 0, 1, 1, 1, -1);

    // Unmapped address from M1 goes to the DECERR slave.
    addr_a[1] = 32'h0005_0000; len_a[1] = 4'd3;
    txn(2'b10, 0, 2, 0, 0, -1);

    // Short burst: WLAST on beat 2 of an AWLEN=3 burst to S0.
    addr_a[0] = 32'h0000_0100; len_a[0] = 4'd3;
    txn(2'b01, 2, 1, 0, 1, -1);

    // Clean burst to S1 with a 3-cycle mid-burst stall; len_err stays sticky.
    addr_a[0] = 32'h0001_0200; len_a[0] = 4'd3;
    txn(2'b01, 0, 0, 3, 2, -1);

    for (int k = 0; k < 20; k++) begin
      addr_a[0] = {hi_tab[$urandom_range(0, 4)], 16'($urandom)};
      addr_a[1] = {hi_tab[$urandom_range(0, 4)], 16'($urandom)};
      len_a[0]  = 4'($urandom_range(0, 3));
      len_a[1]  = 4'($urandom_range(0, 3));
      txn(2'($urandom_range(1, 3)), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1);
    end

    // Reset during the data phase of an S1 burst, then a fresh M1 request.
    addr_a[0] = 32'h0001_0000; len_a[0] = 4'd3;
    txn(2'b01, 0, 0, 0, 0, 2);
    addr_a[1] = 32'h0001_0800; len_a[1] = 4'd1;
    txn(2'b10, 0, 0, 1, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
